soc_system_pio_in_capture: RTL and testbench

//  Avalon-MM slave input PIO: fabric-to-HPS status path, the read-side counterpart of the output PIOs.

---
 rtl/soc_pio_pkg.sv | 21 ++
 rtl/pio_bus_sync.sv | 28 ++
 rtl/soc_system_pio_in_capture.sv | 118 +++++++++++
 tb/tb_soc_system_pio_in_capture.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/soc_pio_pkg.sv
// Shared definitions for the PIO blocks: register map and edge/IRQ mode encodings.
package soc_pio_pkg;

  // Word addresses of the PIO register map
  typedef enum logic [1:0] {
    PIO_ADDR_DATA    = 2'd0,
    PIO_ADDR_RSVD    = 2'd1,
    PIO_ADDR_IRQMASK = 2'd2,
    PIO_ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  // Edge-detect selection
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Interrupt source selection
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_bus_sync.sv
// Multi-flop synchroniser bringing an asynchronous bus into the clk domain.
module pio_bus_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

  // Shift the bus one stage further along the chain every cycle
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  // Chain registers, cleared so no stale bits appear after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign d_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_capture.sv
// Avalon-MM input PIO: synchronised status register, per-bit edge capture
// with write-one-to-clear, interrupt mask and registered IRQ.
module soc_system_pio_in_capture
  import soc_pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_TYPE    = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] irq_src;
  logic             wr_en;
  logic             rd_en;

  // Zero-extend a WIDTH-bit register to the 32-bit bus
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r          = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  pio_bus_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (in_port),
    .d_out (sync_out)
  );

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect &  write_n;

  // Edge detection on the synchronised bus; prev_q starts at 0 so a bit
  // held high through reset release registers exactly one rising edge
  always_comb begin
    data_d = sync_out;
    prev_d = data_q;
    case (EDGE_TYPE)
      EDGE_FALL: edge_det = ~data_q & prev_q;
      EDGE_ANY:  edge_det = data_q ^ prev_q;
      default:   edge_det = data_q & ~prev_q;
    endcase
  end

  // Register writes: mask load, and W1C on edgecapture where a new edge wins
  always_comb begin
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr_en && (pio_addr_e'(address) == PIO_ADDR_IRQMASK)) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && (pio_addr_e'(address) == PIO_ADDR_EDGECAP)) clr_mask  = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
  end

  // Read mux; readdata holds its last value between reads
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (pio_addr_e'(address))
        PIO_ADDR_DATA:    readdata_d = zext(data_q);
        PIO_ADDR_IRQMASK: readdata_d = zext(irqmask_q);
        PIO_ADDR_EDGECAP: readdata_d = zext(edgecap_q);
        default:          readdata_d = '0;
      endcase
    end
  end

  // Interrupt request from masked level or captured edges
  always_comb begin
    irq_src = (IRQ_TYPE == IRQ_EDGE) ? edgecap_q : data_q;
    irq_d   = |(irq_src & irqmask_q);
  end

  // All state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_pio_in_capture.sv
// Bench for the input PIO: reads queue their expected readdata/irq,
// a monitor compares one cycle after each read is sampled.
module tb_soc_system_pio_in_capture;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic        irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
  } exp_t;

  exp_t exp_q[$];
  logic rd_pending;

  soc_system_pio_in_capture #(
    .WIDTH       (32),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .IRQ_TYPE    (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // A read sampled at this edge produces readdata for the next negedge
  always @(posedge clk) rd_pending <= !reset && chipselect && write_n;

  // Monitor: pop one expectation per completed read
  always @(negedge clk) begin
    if (rd_pending) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, readdata, e.exp_rd);
        if (e.chk_irq) check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.exp_irq});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name,
                          input logic chk_irq, input logic exp_irq);
    exp_t e;
    e.name = name; e.exp_rd = exp; e.chk_irq = chk_irq; e.exp_irq = exp_irq;
    exp_q.push_back(e);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0;
  endtask

  initial begin
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = 32'd0; in_port = 32'd0;
    #1 reset = 1'b1;
    #2;
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cycles(2);

    // Reset state of the register map
    bus_read(2'd0, 32'h0, "rst_data", 1'b1, 1'b0);
    bus_read(2'd2, 32'h0, "rst_mask", 1'b0, 1'b0);
    bus_read(2'd3, 32'h0, "rst_edgecap", 1'b0, 1'b0);

    // Sync latency: new value visible to a read issued SYNC_STAGES+1 cycles later
    in_port = 32'hA5A5_0001;
    bus_read(2'd0, 32'h0, "sync_c0", 1'b0, 1'b0);
    bus_read(2'd0, 32'h0, "sync_c1", 1'b0, 1'b0);
    bus_read(2'd0, 32'h0, "sync_c2", 1'b0, 1'b0);
    bus_read(2'd0, 32'hA5A5_0001, "sync_c3", 1'b0, 1'b0);
    cycles(2);
    bus_read(2'd3, 32'hA5A5_0001, "sync_edgecap", 1'b0, 1'b0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, 32'h0, "w1c_all", 1'b0, 1'b0);
    in_port = 32'h0;
    cycles(5);
    bus_read(2'd3, 32'h0, "fall_ignored", 1'b0, 1'b0);

    // Rising capture of a bit3 pulse, then W1C
    in_port = 32'h8; cycles(2); in_port = 32'h0;
    cycles(5);
    bus_read(2'd3, 32'h8, "rise_bit3", 1'b0, 1'b0);
    bus_read(2'd0, 32'h0, "pulse_gone", 1'b0, 1'b0);
    bus_write(2'd3, 32'h8);
    bus_read(2'd3, 32'h0, "w1c_bit3", 1'b0, 1'b0);

    // IRQ from masked edge capture
    bus_write(2'd2, 32'h8);
    cycles(2);
    bus_read(2'd2, 32'h8, "mask_set", 1'b1, 1'b0);
    in_port = 32'h8;
    cycles(6);
    bus_read(2'd3, 32'h8, "irq_rise", 1'b1, 1'b1);
    bus_write(2'd3, 32'h8);
    cycles(2);
    bus_read(2'd3, 32'h0, "irq_w1c", 1'b1, 1'b0);
    in_port = 32'h0; cycles(3); in_port = 32'h8;
    cycles(6);
    bus_read(2'd3, 32'h8, "irq_pend", 1'b1, 1'b1);
    bus_write(2'd2, 32'h0);
    cycles(2);
    bus_read(2'd2, 32'h0, "mask_off", 1'b1, 1'b0);
    bus_read(2'd3, 32'h8, "read_no_clr", 1'b0, 1'b0);

    // Collision: W1C of bit0 in the same cycle its rising edge is detected
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h1);
    in_port = 32'h9;
    cycles(6);
    bus_read(2'd3, 32'h1, "bit0_pend", 1'b1, 1'b1);
    in_port = 32'h8;
    cycles(5);
    in_port = 32'h9;
    cycles(3);
    bus_write(2'd3, 32'h1);
    cycles(1);
    bus_read(2'd3, 32'h1, "collision", 1'b1, 1'b1);

    // Writes to data and reserved addresses have no effect
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    cycles(2);
    bus_read(2'd2, 32'h1, "b2b_mask", 1'b0, 1'b0);
    bus_read(2'd3, 32'h1, "b2b_edgecap", 1'b0, 1'b0);
    bus_read(2'd0, 32'h9, "data_unchanged", 1'b0, 1'b0);
    bus_read(2'd1, 32'h0, "rsvd_zero", 1'b0, 1'b0);

    // Mid-run async reset with edgecapture = 0xF
    in_port = 32'h0; cycles(5);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port = 32'hF;
    cycles(6);
    bus_read(2'd3, 32'hF, "pre_reset_ecap", 1'b1, 1'b1);
    cycles(1);
    in_port = 32'h0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_readdata", readdata, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    cycles(4);
    bus_read(2'd3, 32'h0, "post_rst_ecap", 1'b1, 1'b0);
    bus_read(2'd2, 32'h0, "post_rst_mask", 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycles(1);
    if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
